rtc_millisecond_counter: RTL and testbench

Free-running millisecond timebase that produces the 32-bit `miliseconds` value consumed by the RTC MMIO read interface. It divides the core clock down to 1 ms ticks and maintains a wrap-around millisecond count. The count is software-loadable and has a single compare/alarm register with a sticky pending flag. It sits in core/clock between the system clock source and the RTC read-side interface.

---
 rtl/rtc_millisecond_counter.sv | 88 ++++++++
 tb/tb_rtc_millisecond_counter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_millisecond_counter.sv
// Millisecond timebase for the RTC read path: divides the core clock to 1 ms,
// keeps a loadable wrap-around count and a single compare alarm with a sticky flag.
module rtc_millisecond_counter #(
  parameter int CLOCK_FREQ_HZ   = 50000000,
  parameter int DIVIDER         = CLOCK_FREQ_HZ / 1000,
  parameter int PRESCALER_WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        count_enable,
  input  logic        load_enable,
  input  logic [31:0] load_value,
  input  logic        compare_write,
  input  logic [31:0] compare_value,
  input  logic        alarm_enable,
  input  logic        alarm_ack,
  output logic [31:0] miliseconds,
  output logic        ms_tick,
  output logic        alarm_pending
);

  localparam logic [PRESCALER_WIDTH-1:0] PRESC_LAST = PRESCALER_WIDTH'(DIVIDER - 1);
  localparam logic [31:0]                CMP_RESET  = 32'hFFFF_FFFF;

  logic [PRESCALER_WIDTH-1:0] prescaler_p0;
  logic [31:0]                compare_p0;

  logic [PRESCALER_WIDTH-1:0] presc_next;
  logic [31:0]                ms_next;
  logic                       tick_next;
  logic                       presc_last;
  logic                       alarm_set;
  logic                       pend_next;

  function automatic logic [31:0] inc_wrap(input logic [31:0] v);
    inc_wrap = v + 32'd1;
  endfunction

  // Next-state: load beats increment; increment only on the terminal prescaler count
  always_comb begin
    presc_last = (prescaler_p0 == PRESC_LAST);
    presc_next = prescaler_p0;
    ms_next    = miliseconds;
    tick_next  = 1'b0;
    if (load_enable) begin
      presc_next = '0;
      ms_next    = load_value;
    end else if (count_enable) begin
      if (presc_last) begin
        presc_next = '0;
        ms_next    = inc_wrap(miliseconds);
        tick_next  = 1'b1;
      end else begin
        presc_next = prescaler_p0 + PRESCALER_WIDTH'(1);
      end
    end

    // Alarm fires only on a change of count, so holding at the compare value
    // or reloading the same value never re-arms it; set outranks ack.
    alarm_set = alarm_enable && (ms_next == compare_p0) && (ms_next != miliseconds);
    pend_next = alarm_pending;
    if (alarm_set) begin
      pend_next = 1'b1;
    end else if (alarm_ack) begin
      pend_next = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler_p0  <= '0;
      miliseconds   <= '0;
      ms_tick       <= 1'b0;
      compare_p0    <= CMP_RESET;
      alarm_pending <= 1'b0;
    end else begin
      prescaler_p0  <= presc_next;
      miliseconds   <= ms_next;
      ms_tick       <= tick_next;
      alarm_pending <= pend_next;
      if (compare_write) begin
        compare_p0 <= compare_value;
      end
    end
  end

endmodule

// File: tb/tb_rtc_millisecond_counter.sv
// Bench for rtc_millisecond_counter: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a behavioural model.
module tb_rtc_millisecond_counter;

  localparam int DIV = 4;

  logic        clock;
  logic        reset;
  logic        count_enable;
  logic        load_enable;
  logic [31:0] load_value;
  logic        compare_write;
  logic [31:0] compare_value;
  logic        alarm_enable;
  logic        alarm_ack;
  logic [31:0] miliseconds;
  logic        ms_tick;
  logic        alarm_pending;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  // model state
  logic [31:0] m_ms  = '0;
  logic [31:0] m_cmp = 32'hFFFF_FFFF;
  bit          m_tick = 0;
  bit          m_pend = 0;
  int          m_phase = 0;

  rtc_millisecond_counter #(
    .CLOCK_FREQ_HZ(4000),
    .DIVIDER(DIV),
    .PRESCALER_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .count_enable(count_enable),
    .load_enable(load_enable),
    .load_value(load_value),
    .compare_write(compare_write),
    .compare_value(compare_value),
    .alarm_enable(alarm_enable),
    .alarm_ack(alarm_ack),
    .miliseconds(miliseconds),
    .ms_tick(ms_tick),
    .alarm_pending(alarm_pending)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: count enabled cycles since the last load; every DIV of
  // them adds one millisecond. Alarm = "count just changed onto compare".
  always @(posedge clock) begin
    logic [31:0] nxt;
    if (reset) begin
      m_ms = '0; m_phase = 0; m_tick = 0; m_cmp = 32'hFFFF_FFFF; m_pend = 0;
    end else begin
      nxt = m_ms;
      m_tick = 0;
      if (load_enable) begin
        nxt = load_value;
        m_phase = 0;
      end else if (count_enable) begin
        m_phase = m_phase + 1;
        if (m_phase == DIV) begin
          m_phase = 0;
          nxt = m_ms + 32'd1;
          m_tick = 1;
        end
      end
      if (alarm_enable && nxt == m_cmp && nxt != m_ms) m_pend = 1;
      else if (alarm_ack) m_pend = 0;
      if (compare_write) m_cmp = compare_value;
      m_ms = nxt;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("model_ms", miliseconds, m_ms);
      chk("model_tick", {31'd0, ms_tick}, {31'd0, m_tick});
      chk("model_pend", {31'd0, alarm_pending}, {31'd0, m_pend});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input logic [31:0] v);
    load_enable = 1; load_value = v;
    @(negedge clock);
    load_enable = 0;
  endtask

  task automatic do_ack();
    alarm_ack = 1;
    @(negedge clock);
    alarm_ack = 0;
  endtask

  initial begin
    reset = 1; count_enable = 1; load_enable = 0; load_value = '0;
    compare_write = 0; compare_value = '0; alarm_enable = 0; alarm_ack = 0;
    cyc(3);
    started = 1;
    chk("rst_ms", miliseconds, 32'd0);
    chk("rst_tick", {31'd0, ms_tick}, 32'd0);
    chk("rst_pend", {31'd0, alarm_pending}, 32'd0);

    // tick timing after reset release
    reset = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk("tick_ms", miliseconds, 32'(k / 4));
      chk("tick_pulse", {31'd0, ms_tick}, {31'd0, (k % 4) == 0});
    end

    // pause at prescaler = 2
    cyc(2);
    count_enable = 0;
    cyc(10);
    chk("pause_ms", miliseconds, 32'd2);
    chk("pause_tick", {31'd0, ms_tick}, 32'd0);
    count_enable = 1;
    cyc(1);
    chk("resume1_ms", miliseconds, 32'd2);
    cyc(1);
    chk("resume2_ms", miliseconds, 32'd3);
    chk("resume2_tick", {31'd0, ms_tick}, 32'd1);

    // wrap
    do_load(32'hFFFF_FFFE);
    chk("wrap_load", miliseconds, 32'hFFFF_FFFE);
    chk("wrap_load_tick", {31'd0, ms_tick}, 32'd0);
    cyc(4);
    chk("wrap_ff", miliseconds, 32'hFFFF_FFFF);
    chk("wrap_ff_tick", {31'd0, ms_tick}, 32'd1);
    cyc(4);
    chk("wrap_00", miliseconds, 32'd0);
    chk("wrap_00_tick", {31'd0, ms_tick}, 32'd1);

    // load beats terminal-count increment
    cyc(3);
    do_load(32'd5);
    chk("ldpri_ms", miliseconds, 32'd5);
    chk("ldpri_tick", {31'd0, ms_tick}, 32'd0);
    cyc(3);
    chk("ldpri_hold", miliseconds, 32'd5);
    cyc(1);
    chk("ldpri_next", miliseconds, 32'd6);

    // alarm set and ack
    compare_write = 1; compare_value = 32'd3; alarm_enable = 1;
    do_load(32'd0);
    compare_write = 0;
    chk("al_start_pend", {31'd0, alarm_pending}, 32'd0);
    cyc(11);
    chk("al_pre_ms", miliseconds, 32'd2);
    chk("al_pre_pend", {31'd0, alarm_pending}, 32'd0);
    cyc(1);
    chk("al_hit_ms", miliseconds, 32'd3);
    chk("al_hit_pend", {31'd0, alarm_pending}, 32'd1);
    count_enable = 0;
    do_ack();
    chk("al_ack", {31'd0, alarm_pending}, 32'd0);
    cyc(5);
    chk("al_hold_pend", {31'd0, alarm_pending}, 32'd0);
    chk("al_hold_ms", miliseconds, 32'd3);

    // set and ack in the same cycle
    do_load(32'd2);
    count_enable = 1;
    cyc(3);
    do_ack();
    chk("setack_ms", miliseconds, 32'd3);
    chk("setack_pend", {31'd0, alarm_pending}, 32'd1);
    alarm_enable = 0;
    cyc(2);
    chk("en0_keeps", {31'd0, alarm_pending}, 32'd1);
    do_ack();
    chk("ack_alone", {31'd0, alarm_pending}, 32'd0);

    // disabled alarm does not set
    do_load(32'd2);
    cyc(4);
    chk("gate_ms", miliseconds, 32'd3);
    chk("gate_pend", {31'd0, alarm_pending}, 32'd0);

    // loads onto the compare value
    count_enable = 0; alarm_enable = 1;
    do_load(32'd3);
    chk("ld_same", {31'd0, alarm_pending}, 32'd0);
    do_load(32'd7);
    do_load(32'd3);
    chk("ld_cmp", {31'd0, alarm_pending}, 32'd1);

    // compare write still matches against the old value that cycle
    do_ack();
    do_load(32'd2);
    compare_write = 1; compare_value = 32'd10;
    do_load(32'd3);
    compare_write = 0;
    chk("cw_old", {31'd0, alarm_pending}, 32'd1);
    do_ack();
    do_load(32'd10);
    chk("cw_new", {31'd0, alarm_pending}, 32'd1);

    // reset mid-operation
    do_load(32'd100);
    count_enable = 1;
    reset = 1; load_enable = 1; load_value = 32'd100;
    @(negedge clock);
    reset = 0; load_enable = 0;
    chk("mrst_ms", miliseconds, 32'd0);
    chk("mrst_pend", {31'd0, alarm_pending}, 32'd0);
    chk("mrst_tick", {31'd0, ms_tick}, 32'd0);
    alarm_enable = 1;
    do_load(32'hFFFF_FFFE);
    cyc(4);
    chk("mrst_cmp_ms", miliseconds, 32'hFFFF_FFFF);
    chk("mrst_cmp_pend", {31'd0, alarm_pending}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom % 500) == 0;
      count_enable  = ($urandom % 8) != 0;
      load_enable   = ($urandom % 30) == 0;
      case ($urandom % 4)
        0: load_value = m_cmp;
        1: load_value = m_cmp - 32'd1;
        2: load_value = m_ms;
        default: load_value = $urandom;
      endcase
      compare_write = ($urandom % 40) == 0;
      compare_value = m_ms + 32'($urandom % 6);
      alarm_enable  = ($urandom % 4) != 0;
      alarm_ack     = ($urandom % 10) == 0;
      @(negedge clock);
    end
    reset = 0; load_enable = 0; compare_write = 0; alarm_ack = 0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
